bus_master_arbiter: RTL and testbench

- Generates external bus cycles (address, data, active-low read/write strobes) toward memory-mapped peripherals such as the BASE_ADDRESS register block.
- Shares that bus between two internal requesters using round-robin arbitration.
- Each transaction is a single 8-bit read or write with programmable setup, strobe and hold phases measured in clk cycles.
- The tristate data pin is resolved at the top level from bus_data_out, bus_data_oe and bus_data_in.

---
 rtl/bus_master_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_bus_master_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_arbiter.sv
// Two-requester round-robin master for an external 8-bit asynchronous bus.
// Each grant runs one SETUP/STROBE/HOLD cycle and returns a one-cycle done pulse.
module bus_master_arbiter #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_done,
  output logic [7:0]  req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_done,
  output logic [7:0]  req1_rdata,
  output logic [15:0] address_bus,
  output logic        write_strobe_b,
  output logic        read_strobe_b,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_oe,
  input  logic [7:0]  bus_data_in,
  output logic        busy
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  // A programmed length of 0 behaves as 1, so the reload value saturates at 0.
  localparam logic [CNT_W-1:0] SETUP_LOAD  = (SETUP_CYCLES  == 0) ? '0 : CNT_W'(SETUP_CYCLES  - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = (STROBE_CYCLES == 0) ? '0 : CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = (HOLD_CYCLES   == 0) ? '0 : CNT_W'(HOLD_CYCLES   - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic               rr_ptr;
  logic               gnt_sel;
  logic [ADDR_W-1:0]  lat_addr;
  logic               lat_write;
  logic [DATA_W-1:0]  lat_wdata;
  logic [DATA_W-1:0]  rd_byte;

  logic               phase_end_c;
  logic               grant_c;
  logic               sel_c;
  logic               finish_c;
  logic [ADDR_W-1:0]  txn_addr_c;
  logic               txn_write_c;
  logic [DATA_W-1:0]  txn_wdata_c;

  logic [ADDR_W-1:0]  address_nxt;
  logic               write_strobe_nxt;
  logic               read_strobe_nxt;
  logic [DATA_W-1:0]  data_out_nxt;
  logic               data_oe_nxt;
  logic               busy_nxt;
  logic               done0_nxt;
  logic               done1_nxt;
  logic [DATA_W-1:0]  rdata0_nxt;
  logic [DATA_W-1:0]  rdata1_nxt;

  // Grant is blocked while a done is visible, leaving the requester one cycle to drop valid.
  assign phase_end_c = (cnt == '0);
  assign grant_c     = (state == IDLE) && (req0_valid || req1_valid) && !req0_done && !req1_done;
  assign sel_c       = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
  assign finish_c    = (state == HOLD) && phase_end_c;

  assign txn_addr_c  = grant_c ? (sel_c ? req1_addr  : req0_addr)  : lat_addr;
  assign txn_write_c = grant_c ? (sel_c ? req1_write : req0_write) : lat_write;
  assign txn_wdata_c = grant_c ? (sel_c ? req1_wdata : req0_wdata) : lat_wdata;

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and phase counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (grant_c) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (phase_end_c) begin
          state_nxt = STROBE;
          cnt_nxt   = STROBE_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      STROBE: begin
        if (phase_end_c) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (phase_end_c) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: next values of the registered bus pins, derived from the next state
  always_comb begin
    address_nxt      = '0;
    write_strobe_nxt = 1'b1;
    read_strobe_nxt  = 1'b1;
    data_out_nxt     = '0;
    data_oe_nxt      = 1'b0;
    busy_nxt         = 1'b0;
    done0_nxt        = 1'b0;
    done1_nxt        = 1'b0;
    rdata0_nxt       = req0_rdata;
    rdata1_nxt       = req1_rdata;
    if (state_nxt != IDLE) begin
      address_nxt  = txn_addr_c;
      busy_nxt     = 1'b1;
      data_oe_nxt  = txn_write_c;
      data_out_nxt = txn_write_c ? txn_wdata_c : '0;
      if (state_nxt == STROBE) begin
        write_strobe_nxt = !txn_write_c;
        read_strobe_nxt  = txn_write_c;
      end
    end
    if (finish_c) begin
      done0_nxt = !gnt_sel;
      done1_nxt = gnt_sel;
      if (!lat_write) begin
        if (gnt_sel) rdata1_nxt = rd_byte;
        else         rdata0_nxt = rd_byte;
      end
    end
  end

  // Transaction latches, read capture and round-robin pointer
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rr_ptr    <= 1'b0;
      gnt_sel   <= 1'b0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      rd_byte   <= '0;
    end else begin
      if (grant_c) begin
        gnt_sel   <= sel_c;
        lat_addr  <= txn_addr_c;
        lat_write <= txn_write_c;
        lat_wdata <= txn_wdata_c;
      end
      if ((state == STROBE) && phase_end_c && !lat_write) rd_byte <= bus_data_in;
      if (finish_c) rr_ptr <= !gnt_sel;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      address_bus    <= '0;
      write_strobe_b <= 1'b1;
      read_strobe_b  <= 1'b1;
      bus_data_out   <= '0;
      bus_data_oe    <= 1'b0;
      busy           <= 1'b0;
      req0_done      <= 1'b0;
      req1_done      <= 1'b0;
      req0_rdata     <= '0;
      req1_rdata     <= '0;
    end else begin
      address_bus    <= address_nxt;
      write_strobe_b <= write_strobe_nxt;
      read_strobe_b  <= read_strobe_nxt;
      bus_data_out   <= data_out_nxt;
      bus_data_oe    <= data_oe_nxt;
      busy           <= busy_nxt;
      req0_done      <= done0_nxt;
      req1_done      <= done1_nxt;
      req0_rdata     <= rdata0_nxt;
      req1_rdata     <= rdata1_nxt;
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter: default-timing DUT plus a slow-timing (3/4/2) DUT.
module tb_bus_master_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_b;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [15:0] req0_addr, req1_addr;
  logic [7:0]  req0_wdata, req1_wdata;
  logic        req0_done, req1_done;
  logic [7:0]  req0_rdata, req1_rdata;
  logic [15:0] address_bus;
  logic        write_strobe_b, read_strobe_b, bus_data_oe, busy;
  logic [7:0]  bus_data_out, bus_data_in;

  logic        p_req0_valid, p_req0_write, p_req1_valid, p_req1_write;
  logic [15:0] p_req0_addr, p_req1_addr;
  logic [7:0]  p_req0_wdata, p_req1_wdata;
  logic        p_req0_done, p_req1_done;
  logic [7:0]  p_req0_rdata, p_req1_rdata;
  logic [15:0] p_address_bus;
  logic        p_write_strobe_b, p_read_strobe_b, p_bus_data_oe, p_busy;
  logic [7:0]  p_bus_data_out, p_bus_data_in;

  int total = 0;
  int bad   = 0;

  // {address, wstrb_b, rstrb_b, oe, data_out, busy, done0, done1}
  wire [29:0] obs = {address_bus, write_strobe_b, read_strobe_b, bus_data_oe,
                     bus_data_out, busy, req0_done, req1_done};

  bus_master_arbiter dut (
    .clk(clk), .reset_b(reset_b),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
    .address_bus(address_bus), .write_strobe_b(write_strobe_b), .read_strobe_b(read_strobe_b),
    .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in),
    .busy(busy)
  );

  bus_master_arbiter #(.SETUP_CYCLES(3), .STROBE_CYCLES(4), .HOLD_CYCLES(2)) dut_p (
    .clk(clk), .reset_b(reset_b),
    .req0_valid(p_req0_valid), .req0_write(p_req0_write), .req0_addr(p_req0_addr),
    .req0_wdata(p_req0_wdata), .req0_done(p_req0_done), .req0_rdata(p_req0_rdata),
    .req1_valid(p_req1_valid), .req1_write(p_req1_write), .req1_addr(p_req1_addr),
    .req1_wdata(p_req1_wdata), .req1_done(p_req1_done), .req1_rdata(p_req1_rdata),
    .address_bus(p_address_bus), .write_strobe_b(p_write_strobe_b), .read_strobe_b(p_read_strobe_b),
    .bus_data_out(p_bus_data_out), .bus_data_oe(p_bus_data_oe), .bus_data_in(p_bus_data_in),
    .busy(p_busy)
  );

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    bus_data_in = '0;
    p_req0_valid = 1'b0; p_req0_write = 1'b0; p_req0_addr = '0; p_req0_wdata = '0;
    p_req1_valid = 1'b0; p_req1_write = 1'b0; p_req1_addr = '0; p_req1_wdata = '0;
    p_bus_data_in = '0;
  endtask

  task automatic test_reset();
    logic [29:0] exp;
    reset_b = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    exp = {16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL reset_held: got %h want %h", obs, exp);
    end
    total++;
    if ({req0_rdata, req1_rdata} !== 16'h0000) begin
      bad++; $display("FAIL reset_rdata: got %h want 0000", {req0_rdata, req1_rdata});
    end
    reset_b = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL reset_idle cycle %0d: got %h want %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_single_write();
    logic [29:0] exp;
    logic        act;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 16'hA000; req0_wdata = 8'h5A;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        req0_valid = 1'b0; req0_addr = 16'hFFFF; req0_wdata = 8'hFF;
      end
      @(negedge clk);
      act = (k >= 1) && (k <= 4);
      exp = {act ? 16'hA000 : 16'h0000, !((k == 2) || (k == 3)), 1'b1, act,
             act ? 8'h5A : 8'h00, act, (k == 5), 1'b0};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL write cycle %0d: got %h want %h", k, obs, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_single_read();
    logic [29:0] exp;
    logic        act;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 16'hA001;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 1) req1_valid = 1'b0;
      if (k == 2) bus_data_in = 8'hC3;
      if (k == 4) bus_data_in = 8'h00;
      @(negedge clk);
      act = (k >= 1) && (k <= 4);
      exp = {act ? 16'hA001 : 16'h0000, 1'b1, !((k == 2) || (k == 3)), 1'b0,
             8'h00, act, 1'b0, (k == 5)};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL read cycle %0d: got %h want %h", k, obs, exp);
      end
      if (k == 5) begin
        total++;
        if (req1_rdata !== 8'hC3) begin
          bad++; $display("FAIL read_rdata1: got %h want c3", req1_rdata);
        end
        total++;
        if (req0_rdata !== 8'h00) begin
          bad++; $display("FAIL read_rdata0_kept: got %h want 00", req0_rdata);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    int dcyc[4];
    int didx[4];
    int ndone = 0;
    reset_b = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 16'h1000; req0_wdata = 8'h11;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 16'h2000; req1_wdata = 8'h22;
    for (int i = 0; i < 4; i++) begin dcyc[i] = -1; didx[i] = -1; end
    @(posedge clk); #1;
    reset_b = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (read_strobe_b !== 1'b1) begin
        bad++; $display("FAIL contention_rstrb cycle %0d: got %b want 1", k, read_strobe_b);
      end
      if (write_strobe_b === 1'b0) begin
        total++;
        if (address_bus !== ((ndone % 2 == 0) ? 16'h1000 : 16'h2000)) begin
          bad++; $display("FAIL contention_addr cycle %0d: got %h want %h", k, address_bus,
                          (ndone % 2 == 0) ? 16'h1000 : 16'h2000);
        end
      end
      if ((req0_done === 1'b1) || (req1_done === 1'b1)) begin
        if (ndone < 4) begin
          dcyc[ndone] = k;
          didx[ndone] = (req1_done === 1'b1) ? 1 : 0;
        end
        ndone++;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    total++;
    if (ndone != 4) begin
      bad++; $display("FAIL contention_count: got %0d want 4", ndone);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ((dcyc[i] != 5 + 6 * i) || (didx[i] != i % 2)) begin
        bad++; $display("FAIL contention_done %0d: got cycle %0d req %0d want cycle %0d req %0d",
                        i, dcyc[i], didx[i], 5 + 6 * i, i % 2);
      end
    end
  endtask

  task automatic test_param_timing();
    int scnt = 0;
    int acnt = 0;
    int dcyc = -1;
    @(posedge clk); #1;
    p_req0_valid = 1'b1; p_req0_write = 1'b1; p_req0_addr = 16'hBEEF; p_req0_wdata = 8'h77;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) p_req0_valid = 1'b0;
      @(negedge clk);
      if (p_write_strobe_b === 1'b0) scnt++;
      if (p_address_bus === 16'hBEEF) acnt++;
      if ((p_req0_done === 1'b1) && (dcyc < 0)) dcyc = k;
      total++;
      if (p_write_strobe_b !== !((k >= 4) && (k <= 7))) begin
        bad++; $display("FAIL param_wstrb cycle %0d: got %b want %b", k, p_write_strobe_b,
                        !((k >= 4) && (k <= 7)));
      end
    end
    idle_inputs();
    total++;
    if (scnt != 4) begin
      bad++; $display("FAIL param_strobe_len: got %0d want 4", scnt);
    end
    total++;
    if (acnt != 9) begin
      bad++; $display("FAIL param_addr_len: got %0d want 9", acnt);
    end
    total++;
    if (dcyc != 10) begin
      bad++; $display("FAIL param_latency: got %0d want 10", dcyc);
    end
  endtask

  task automatic test_reset_mid();
    logic got = 1'b0;
    int   dcyc = -1;
    int   didx = -1;
    // Complete one req0 write so the pointer favours req1 before the abort.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 16'h3000; req0_wdata = 8'h10;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req0_done === 1'b1) begin got = 1'b1; break; end
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL midreset_warmup: got no done want done within 20 cycles");
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 16'h4000; req0_wdata = 8'h55;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (write_strobe_b !== 1'b0) begin
      bad++; $display("FAIL midreset_in_strobe: got %b want 0", write_strobe_b);
    end
    #1 reset_b = 1'b0;
    #1;
    total++;
    if ({address_bus, write_strobe_b, bus_data_oe, busy, req0_done} !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL midreset_async: got %h want %h",
                      {address_bus, write_strobe_b, bus_data_oe, busy, req0_done},
                      {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 16'h5000; req0_wdata = 8'h66;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 16'h6000; req1_wdata = 8'h77;
    @(posedge clk); #1;
    reset_b = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (((req0_done === 1'b1) || (req1_done === 1'b1)) && (dcyc < 0)) begin
        dcyc = k;
        didx = (req1_done === 1'b1) ? 1 : 0;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    total++;
    if ((dcyc != 5) || (didx != 0)) begin
      bad++; $display("FAIL midreset_pointer: got cycle %0d req %0d want cycle 5 req 0", dcyc, didx);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_param_timing();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
